// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter; master = producers plus UART TX model, slave = arbiter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_par_en;
   logic [NUM_REQ-1:0]            req_par_type;
   logic [NUM_REQ-1:0]            grant;
   logic [NUM_REQ-1:0]            done;
   logic [DATA_WIDTH-1:0]         tx_data;
   logic                          tx_data_valid;
   logic                          tx_parity_en;
   logic                          tx_parity_type;
   logic                          tx_busy;
   logic                          timeout_err;

   modport master (
      output req, req_data, req_par_en, req_par_type, tx_busy,
      input  grant, done, tx_data, tx_data_valid, tx_parity_en, tx_parity_type, timeout_err
   );

   modport slave (
      input  req, req_data, req_par_en, req_par_type, tx_busy,
      output grant, done, tx_data, tx_data_valid, tx_parity_en, tx_parity_type, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ requesters; one frame in flight at a time.
// Optional launch timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic               clk,
   input logic               rst,
   uart_tx_arbiter_if.slave  bus
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_COMPLETE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [PW-1:0]         r_ptr;
   logic [PW-1:0]         r_gidx;
   logic [NUM_REQ-1:0]    r_grant;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic                  r_par_en;
   logic                  r_par_type;
   logic                  w_any;
   logic [PW-1:0]         w_sel;
   logic [NUM_REQ-1:0]    w_sel_oh;
   logic                  w_start;
   logic                  w_timeout;

   function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] p, input int off);
      int s;
      s = int'(p) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return PW'(s);
   endfunction

   // Descending scan so the requester closest to r_ptr is the last (winning) assignment.
   always_comb begin
      w_any = 1'b0;
      w_sel = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req[f_wrap(r_ptr, i)]) begin
            w_any = 1'b1;
            w_sel = f_wrap(r_ptr, i);
         end
      end
   end

   assign w_sel_oh = NUM_REQ'(1) << w_sel;
   assign w_start  = (r_state == S_IDLE) && w_any && !bus.tx_busy;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_to_cnt;
   logic             r_timeout;
   logic             w_to_hit;

   assign w_to_hit = (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == S_LAUNCH)
            r_to_cnt <= '0;
         else if (r_state == S_WAIT_BUSY)
            r_to_cnt <= r_to_cnt + CNT_W'(1);
         r_timeout <= w_timeout;
      end
   end

   assign bus.timeout_err = (r_state == S_COMPLETE) && r_timeout;
`else
   assign bus.timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE:      if (w_start) w_state_nxt = S_LAUNCH;
         S_LAUNCH:    w_state_nxt = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (bus.tx_busy) begin
               w_state_nxt = S_WAIT_DONE;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (w_to_hit) begin
               w_state_nxt = S_COMPLETE;
               w_timeout   = 1'b1;
            end
`endif
         end
         S_WAIT_DONE: if (!bus.tx_busy) w_state_nxt = S_COMPLETE;
         S_COMPLETE:  w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   // Selection snapshot: later changes on the requester side are ignored until the next selection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr      <= '0;
         r_gidx     <= '0;
         r_grant    <= '0;
         r_tx_data  <= '0;
         r_par_en   <= 1'b0;
         r_par_type <= 1'b0;
      end else begin
         if (w_start) begin
            r_gidx     <= w_sel;
            r_grant    <= w_sel_oh;
            r_tx_data  <= bus.req_data[w_sel*DATA_WIDTH +: DATA_WIDTH];
            r_par_en   <= bus.req_par_en[w_sel];
            r_par_type <= bus.req_par_type[w_sel];
         end
         if (r_state == S_COMPLETE) begin
            r_grant <= '0;
            r_ptr   <= f_wrap(r_gidx, 1);
         end
      end
   end

   assign bus.grant          = r_grant;
   assign bus.done           = (r_state == S_COMPLETE) ? r_grant : '0;
   assign bus.tx_data_valid  = (r_state == S_LAUNCH);
   assign bus.tx_data        = r_tx_data;
   assign bus.tx_parity_en   = r_par_en;
   assign bus.tx_parity_type = r_par_type;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter against a round-robin reference model.
module tb_uart_tx_arbiter;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(8)) ifc ();

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   int         m_ptr = 0;
   logic [7:0] b_data [N];
   logic       b_pen  [N];
   logic       b_ptype[N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bytes();
      for (int i = 0; i < N; i++) begin
         ifc.req_data[i*8 +: 8] = b_data[i];
         ifc.req_par_en[i]      = b_pen[i];
         ifc.req_par_type[i]    = b_ptype[i];
      end
   endtask

   function automatic int model_pick(input logic [N-1:0] r);
      for (int i = 0; i < N; i++)
         if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
      return -1;
   endfunction

   task automatic wait_launch(input string tag, input int exp_lat);
      int n;
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (ifc.tx_data_valid) break;
      end
      chk({tag, "_lat"}, n, exp_lat);
   endtask

   // One frame: launch at expected latency, busy for busy_len cycles, done one cycle after busy falls.
   task automatic run_frame(input string tag, input int exp_lat, input int busy_len, input bit mangle);
      int         idx;
      logic [7:0] eb;
      logic       ep, et;
      idx = model_pick(ifc.req);
      eb  = b_data[idx];
      ep  = b_pen[idx];
      et  = b_ptype[idx];
      wait_launch(tag, exp_lat);
      chk({tag, "_grant"}, ifc.grant, 1 << idx);
      chk({tag, "_data"},  ifc.tx_data, eb);
      chk({tag, "_par"},   {ifc.tx_parity_en, ifc.tx_parity_type}, {ep, et});
      ifc.tx_busy = 1'b1;
      if (mangle) begin
         b_data[idx] = ~b_data[idx];
         drive_bytes();
      end
      @(negedge clk);
      chk({tag, "_vld1"}, ifc.tx_data_valid, 1'b0);
      repeat (busy_len - 1) @(negedge clk);
      chk({tag, "_nodone"}, ifc.done, 0);
      if (mangle) ifc.req[idx] = 1'b0;
      ifc.tx_busy = 1'b0;
      @(negedge clk);
      chk({tag, "_done"}, ifc.done, 1 << idx);
      chk({tag, "_hold"}, ifc.tx_data, eb);
      chk({tag, "_terr"}, ifc.timeout_err, 1'b0);
      m_ptr = (idx + 1) % N;
   endtask

   initial begin
      int   n;
      logic quiet;
      ifc.req     = '0;
      ifc.tx_busy = 1'b0;
      for (int i = 0; i < N; i++) begin
         b_data[i] = '0; b_pen[i] = 1'b0; b_ptype[i] = 1'b0;
      end
      drive_bytes();
      #1;
      chk("rst_grant", ifc.grant, 0);
      chk("rst_vld",   ifc.tx_data_valid, 1'b0);
      chk("rst_done",  ifc.done, 0);
      chk("rst_out",   {ifc.tx_data, ifc.tx_parity_en, ifc.tx_parity_type, ifc.timeout_err}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single request, long frame
      @(negedge clk);
      b_data[0] = 8'h4B; b_pen[0] = 1'b1; b_ptype[0] = 1'b1;
      drive_bytes();
      ifc.req = 4'b0001;
      run_frame("single", 1, 110, 1'b0);

      // All four, then only 0 and 2
      for (int i = 0; i < N; i++) begin
         b_data[i] = 8'((i + 1) * 8'h11); b_pen[i] = i[0]; b_ptype[i] = i[1];
      end
      drive_bytes();
      ifc.req = 4'b1111;
      for (int f = 0; f < 4; f++) run_frame("all4", 2, 3, 1'b0);
      ifc.req = 4'b0101;
      for (int f = 0; f < 4; f++) run_frame("r02", 2, 2, 1'b0);

      // Data change after launch, req drop in WAIT_DONE
      b_data[1] = 8'hA5;
      drive_bytes();
      ifc.req = 4'b0010;
      run_frame("mangle", 2, 4, 1'b1);

      // Randomized requests, bytes and frame lengths
      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < N; i++) begin
            b_data[i]  = 8'($urandom);
            b_pen[i]   = 1'($urandom);
            b_ptype[i] = 1'($urandom);
         end
         drive_bytes();
         ifc.req = 4'($urandom_range(1, 15));
         run_frame("rand", 2, $urandom_range(2, 8), 1'b0);
      end

      // External frame in flight: no launch until busy falls
      ifc.tx_busy = 1'b1;
      ifc.req     = 4'b0010;
      quiet = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (ifc.tx_data_valid || ifc.grant != 0) quiet = 1'b0;
      end
      chk("ext_busy_quiet", quiet, 1'b1);
      ifc.tx_busy = 1'b0;
      run_frame("ext_busy", 1, 3, 1'b0);

      // Reset during WAIT_DONE
      ifc.req = 4'b0100;
      wait_launch("rst_mid", 2);
      ifc.tx_busy = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_grant", ifc.grant, 0);
      chk("rst_mid_sig",   {ifc.tx_data_valid, ifc.done}, 0);
      @(negedge clk);
      chk("rst_mid_nodone", ifc.done, 0);
      ifc.tx_busy = 1'b0;
      ifc.req     = 4'b1001;
      m_ptr = 0;
      @(negedge clk);
      rst = 1'b0;
      run_frame("post_rst0", 1, 2, 1'b0);
      run_frame("post_rst3", 2, 2, 1'b0);

      // Transmitter never raises busy
      ifc.req = 4'b0011;
      n = model_pick(ifc.req);
      wait_launch("noresp", 2);
`ifdef UART_ARB_TIMEOUT_EN
      begin
         int k;
         k = 0;
         while (k < 40) begin
            @(negedge clk);
            k++;
            if (ifc.done != 0) break;
         end
         chk("to_delay", k, 17);
         chk("to_done",  ifc.done, 1 << n);
         chk("to_err",   ifc.timeout_err, 1'b1);
         m_ptr = (n + 1) % N;
         run_frame("to_next", 2, 2, 1'b0);
      end
`else
      quiet = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (ifc.done != 0 || ifc.timeout_err) quiet = 1'b0;
      end
      chk("noto_quiet", quiet, 1'b1);
      chk("noto_grant", ifc.grant, 1 << n);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
